instr_encoder: RTL

//  Inverse of the instruction decode path. Accepts decoded instruction fields over a

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction field bundles into 32-bit words and streams them
// to consecutive instruction-memory addresses, rejecting out-of-range fields.
module instr_encoder #(
   parameter int   ADDR_W     = 10,
   parameter logic BRANCH_B30 = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_kind,
   input  logic [4:0]        in_op,
   input  logic              in_imm_reg,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic [ADDR_W:0]   count,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // Memory opcode block LW..SB occupies 5'h10..5'h15
   localparam logic [4:0] OP_LW = 5'h10;
   localparam logic [4:0] OP_SB = 5'h15;

   localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
   localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
   localparam logic signed [31:0] IMM16_MIN = -32'sd32768;
   localparam logic signed [31:0] IMM16_MAX = 32'sd32767;

   state_t      state;
   logic [31:0] word;
   logic        bad_imm;
   logic        bad_op;
   logic [4:0]  br_op;
   logic        accept;
   logic        done;

   assign in_ready = (state == RUN) && (!imem_we || imem_ready);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign done     = imem_we && imem_ready;
   assign br_op    = {1'b1, BRANCH_B30, in_op[2:0]};

   always_comb begin
      word        = '0;
      bad_imm     = 1'b0;
      bad_op      = 1'b0;
      word[26:22] = in_rd;
      word[21:17] = in_rs1;
      unique case (in_kind)
         2'd0: begin
            word[30:28] = in_op[2:0];
            word[16:12] = in_rs2;
            word[11:0]  = in_imm[11:0];
            bad_imm = ($signed(in_imm) < IMM12_MIN) ||
                      ($signed(in_imm) > IMM12_MAX);
         end
         2'd1: begin
            word[30:28] = in_op[2:0];
            word[27]    = 1'b1;
            word[16:1]  = in_imm[15:0];
            word[0]     = in_imm_reg;
            bad_imm = ($signed(in_imm) < IMM16_MIN) ||
                      ($signed(in_imm) > IMM16_MAX);
         end
         2'd2: begin
            word[31:27] = in_op;
            word[16:1]  = in_imm[15:0];
            bad_imm = ($signed(in_imm) < IMM16_MIN) ||
                      ($signed(in_imm) > IMM16_MAX);
            bad_op  = (in_op < OP_LW) || (in_op > OP_SB);
         end
         default: begin
            word[31:27] = br_op;
            word[16:1]  = in_imm[15:0];
            bad_imm = ($signed(in_imm) < IMM16_MIN) ||
                      ($signed(in_imm) > IMM16_MAX);
            bad_op  = (in_op[2:0] == 3'b111) ||
                      ((br_op >= OP_LW) && (br_op <= OP_SB));
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         count      <= '0;
         err        <= 1'b0;
         err_code   <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  imem_addr <= base_addr;
                  count     <= '0;
                  err       <= 1'b0;
                  err_code  <= 2'd0;
               end
            end
            RUN: begin
               if (done) begin
                  imem_we   <= 1'b0;
                  imem_addr <= imem_addr + 1'b1;
                  count     <= count + 1'b1;
               end
               if (accept) begin
                  if (bad_op || bad_imm) begin
                     err <= 1'b1;
                     if (!err) err_code <= bad_op ? 2'd2 : 2'd1;
                  end else begin
                     imem_we    <= 1'b1;
                     imem_wdata <= word;
                  end
                  // A rejected final bundle leaves nothing to drain
                  if (in_last)
                     state <= (bad_op || bad_imm) ? IDLE : DRAIN;
               end
            end
            default: begin
               if (done) begin
                  imem_we   <= 1'b0;
                  imem_addr <= imem_addr + 1'b1;
                  count     <= count + 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
